// File: rtl/rv32_mod_decode_queue.sv
// RV32 decode queue: decodes fetched words and buffers them in a small FIFO.
// Define RV32_DECODE_IMM_EN to generate and store the sign-extended immediate.
module rv32_mod_decode_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rf_read0_index,
  output logic [4:0]               out_rf_read1_index,
  output logic [4:0]               out_rf_write0_index,
  output logic [5:0]               out_instruction_format,
  output logic [4:0]               out_func,
  output logic                     out_is_mem_or_io,
  output logic                     out_is_compressed,
  output logic                     out_illegal,
  output logic [XLEN-1:0]          out_imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [5:0]      fmt;
    logic [4:0]      func;
    logic            mem;
    logic            cmp;
    logic            ill;
  } rec_t;

  logic [31:0] inst;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic        full32;
  logic        known;
  logic        legal;
  logic        f_r, f_i, f_s, f_b, f_u, f_j;
  logic        op_load, op_fence, op_imm, op_auipc;
  logic        op_imm32, op_st, op_op, op_lui;
  logic        op_br, op_jalr, op_jal, op_sys;
  rec_t        d;

  assign inst   = in_instruction;
  assign opc    = inst[6:2];
  assign f3     = inst[14:12];
  assign full32 = inst[1:0] == 2'b11;

  assign op_load  = opc == 5'b00000;
  assign op_fence = opc == 5'b00011;
  assign op_imm   = opc == 5'b00100;
  assign op_auipc = opc == 5'b00101;
  assign op_imm32 = opc == 5'b00110;
  assign op_st    = opc == 5'b01000;
  assign op_op    = opc == 5'b01100;
  assign op_lui   = opc == 5'b01101;
  assign op_br    = opc == 5'b11000;
  assign op_jalr  = opc == 5'b11001;
  assign op_jal   = opc == 5'b11011;
  assign op_sys   = opc == 5'b11100;

  always_comb begin
    f_r   = 1'b0;
    f_i   = 1'b0;
    f_s   = 1'b0;
    f_b   = 1'b0;
    f_u   = 1'b0;
    f_j   = 1'b0;
    known = 1'b1;
    unique case (1'b1)
      op_load, op_fence, op_imm,
      op_imm32, op_jalr, op_sys: f_i = 1'b1;
      op_lui, op_auipc:          f_u = 1'b1;
      op_op:                     f_r = 1'b1;
      op_jal: begin
        f_u = 1'b1;
        f_j = 1'b1;
      end
      op_br: begin
        f_s = 1'b1;
        f_b = 1'b1;
      end
      op_st:                     f_s = 1'b1;
      default:                   known = 1'b0;
    endcase
  end

  assign legal = full32 && known &&
                 (inst != 32'h0) && (inst != 32'hffff_ffff);

  always_comb begin
    d      = '0;
    d.pc   = in_pc;
    d.cmp  = !full32;
    d.ill  = !legal;
    if (legal) begin
      d.rs1  = f_u ? 5'd0 : inst[19:15];
      d.rs2  = (f_u || f_i) ? 5'd0 : inst[24:20];
      d.rd   = f_s ? 5'd0 : inst[11:7];
      d.fmt  = {f_r, f_i, f_s, f_b, f_u, f_j};
      d.func = {op_op & inst[25],
                (op_op | (op_imm & (f3 == 3'b101))) & inst[30],
                f3};
      d.mem  = op_load | op_st;
    end
  end

  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          rdy_en;
  logic          push, pop;
  rec_t          mem [DEPTH];
  rec_t          head;

  assign in_ready  = rdy_en && (cnt < CW'(DEPTH));
  assign out_valid = cnt != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop)  rp <= rp + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: reads are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= d;
  end

  assign head = out_valid ? mem[rp] : '0;

  assign out_pc                 = head.pc;
  assign out_rf_read0_index     = head.rs1;
  assign out_rf_read1_index     = head.rs2;
  assign out_rf_write0_index    = head.rd;
  assign out_instruction_format = head.fmt;
  assign out_func               = head.func;
  assign out_is_mem_or_io       = head.mem;
  assign out_is_compressed      = head.cmp;
  assign out_illegal            = head.ill;

`ifdef RV32_DECODE_IMM_EN
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] imm_q [DEPTH];

  // Branch also flags S, so the B test must come before S.
  always_comb begin
    d_imm = '0;
    if (!legal || f_r) begin
      d_imm = '0;
    end else if (f_j) begin
      d_imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                             inst[30:21], 1'b0}));
    end else if (f_u) begin
      d_imm = XLEN'($signed({inst[31:12], 12'b0}));
    end else if (f_b) begin
      d_imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                             inst[11:8], 1'b0}));
    end else if (f_s) begin
      d_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
    end else begin
      d_imm = XLEN'($signed(inst[31:20]));
    end
  end

  always_ff @(posedge clk) begin
    if (push) imm_q[wp] <= d_imm;
  end

  assign out_imm = out_valid ? imm_q[rp] : '0;
`else
  assign out_imm = '0;
`endif

endmodule

// File: doc/rv32_mod_decode_queue.md
RV32_MOD_DECODE_QUEUE -- requirements
Module: rv32_mod_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of decoded-instruction entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, width of PC and immediate fields.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard all queued entries.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1, upstream handshake.
REQ-007 SHALL have ports in_instruction input 32 and in_pc input XLEN, the fetched word and its address.
REQ-008 SHALL have ports out_valid output 1 / out_ready input 1, downstream handshake.
REQ-009 SHALL have port out_pc  output  XLEN  PC of the head entry.
REQ-010 SHALL have ports out_rf_read0_index, out_rf_read1_index, out_rf_write0_index  output  5 each  register indices.
REQ-011 SHALL have port out_instruction_format  output  6  {r, i, s, s_sub_b, u, u_sub_j}.
REQ-012 SHALL have port out_func  output  5  decoded function code.
REQ-013 SHALL have ports out_is_mem_or_io, out_is_compressed, out_illegal  output  1 each.
REQ-014 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL decode in_instruction combinationally and write the decoded record plus in_pc into the queue when in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH), independent of out_ready (no combinational ready path).
REQ-018 SHALL have latency of one cycle: an entry accepted on edge N is visible with out_valid=1 after edge N, with no same-cycle bypass.
REQ-019 SHALL drive out_valid = (count != 0) and pop the head on out_valid && out_ready.
REQ-020 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL, when flush=1, clear count and both pointers at the next edge and ignore push/pop in that cycle.
REQ-023 SHALL classify opcode[6:2] by type: OP-IMM, OP-IMM-32, JALR, LOAD, MISC-MEM and SYSTEM as I; LUI and AUIPC as U; OP as R; JAL as U+J; BRANCH as S+B; STORE as S.
REQ-024 SHALL set is_mem_or_io only for LOAD and STORE.
REQ-025 SHALL set out_illegal for compressed words (bits[1:0]!=11), for unlisted opcodes, and for 0x00000000 and 0xFFFFFFFF.
REQ-026 SHALL set is_compressed = (bits[1:0] != 2'b11).
REQ-027 SHALL zero read0 for U-type, read1 for U-type and I-type, and write0 for S-type (including B).
REQ-028 SHALL zero all indices, the format field, func and imm for illegal entries.
REQ-029 SHALL form func[2:0]=funct3, func[3]=funct7[5] for OP or (OP-IMM with funct3=101) else 0, and func[4]=funct7[0] for OP else 0.

Reset
REQ-030 SHALL, while rstn=0, force count=0, both pointers to 0, out_valid=0 and in_ready=0, with all out_* record fields reading 0.
REQ-031 SHALL discard queued entries on mid-operation reset and raise in_ready on the first edge after rstn rises.

Configuration
REQ-032 SHALL, with RV32_DECODE_IMM_EN defined, generate out_imm as I=sext(inst[31:20]), S=sext({[31:25],[11:7]}), B=sext({[31],[7],[30:25],[11:8],0}), U={[31:12],12'b0}, J=sext({[31],[19:12],[20],[30:21],0}), and R=0.
REQ-033 SHALL, without RV32_DECODE_IMM_EN, store no immediate bits and tie out_imm to 0.

Verification
REQ-034 SHALL cover: push 0x00510093 (addi x1,x2,5), pc 0x100 -> next cycle read0=2, read1=0, write0=1, format=010000, func=00000, imm=5, out_pc=0x100.
REQ-035 SHALL cover: push 0x00532423 (sw x5,8(x6)) -> read0=6, read1=5, write0=0, format=001000, is_mem_or_io=1, imm=8.
REQ-036 SHALL cover: DEPTH=2 with out_ready=0, three pushes -> in_ready=0 after the second, count=2; one pop frees the slot and the third word is accepted in order.
REQ-037 SHALL cover: push 0x00004501 -> out_illegal=1, is_compressed=1, all indices/format/func=0.
REQ-038 SHALL cover: full queue with flush=1 for one cycle -> count=0 and out_valid=0 next cycle; a push in the flush cycle is dropped.
REQ-039 SHALL cover: rstn pulsed low asynchronously with count=2 -> out_valid=0 immediately, count=0, queue empty after release.
